// File: rtl/imm_ext_unit.sv
// Immediate-extension stage between decode and the ALU/branch operand mux.
// Extends the raw immediate by opcode class and queues results in a 2-entry buffer.
module imm_ext_unit #(
    parameter int IMM_W    = 16,
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2,
    parameter int CNT_W    = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              In_valid,
    output logic              In_ready,
    input  logic [5:0]        Opcode,
    input  logic [IMM_W-1:0]  Immed_in,
    output logic              Out_valid,
    input  logic              Out_ready,
    output logic [DATA_W-1:0] Immed_out,
    output logic              Illegal_out,
    output logic              Err_sticky,
    input  logic              Err_clr,
    output logic [CNT_W-1:0]  Illegal_cnt
);

    // Returns {illegal, extended_value}; unmapped opcodes yield zero data.
    function automatic logic [DATA_W:0] extend_imm(input logic [5:0] op,
                                                   input logic [IMM_W-1:0] imm);
        logic signed [IMM_W-1:0]  imm_s;
        logic signed [DATA_W-1:0] sext;
        logic [DATA_W:0]          res;
        imm_s = imm;
        sext  = DATA_W'(imm_s);
        res   = '0;
        case (op)
            6'b111000, 6'b110000, 6'b000011,
            6'b000111, 6'b001111, 6'b011111: res = {1'b0, sext};
            6'b110010, 6'b110011:            res = {1'b0, {(DATA_W-IMM_W){1'b0}}, imm};
            6'b111001:                       res = {1'b0, imm, {(DATA_W-IMM_W){1'b0}}};
            6'b111111, 6'b000000, 6'b000001: res = {1'b0, sext <<< BR_SHIFT};
            default:                         res = {1'b1, {DATA_W{1'b0}}};
        endcase
        return res;
    endfunction

    logic [DATA_W-1:0] ext_data_p0;
    logic              ext_ill_p0;
    logic              vld_p0;
    logic              pop;

    logic [DATA_W-1:0] buf_data_p1 [2];
    logic              buf_ill_p1  [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    // Stage p0: combinational extension of the incoming request
    assign {ext_ill_p0, ext_data_p0} = extend_imm(Opcode, Immed_in);

    assign In_ready  = (count < 2'd2);
    assign Out_valid = (count != 2'd0);
    assign vld_p0    = In_valid && In_ready;
    assign pop       = Out_valid && Out_ready;

    // Stage p1: buffered results; payload is not reset, only the control around it
    always_ff @(posedge Clk) begin
        if (vld_p0) begin
            buf_data_p1[wr_ptr] <= ext_data_p0;
            buf_ill_p1[wr_ptr]  <= ext_ill_p0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (vld_p0) wr_ptr <= ~wr_ptr;
            if (pop)    rd_ptr <= ~rd_ptr;
            case ({vld_p0, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Set has priority over clear so an illegal accept is never lost
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Err_sticky  <= 1'b0;
            Illegal_cnt <= '0;
        end else begin
            if (vld_p0 && ext_ill_p0) begin
                Err_sticky <= 1'b1;
                if (Illegal_cnt != {CNT_W{1'b1}}) Illegal_cnt <= Illegal_cnt + CNT_W'(1);
            end else if (Err_clr) begin
                Err_sticky <= 1'b0;
            end
        end
    end

    always_comb begin
        Immed_out   = '0;
        Illegal_out = 1'b0;
        if (Out_valid) begin
            Immed_out   = buf_data_p1[rd_ptr];
            Illegal_out = buf_ill_p1[rd_ptr];
        end
    end

endmodule
